// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx byte transmitter between N_REQ byte
// sources. Arbitration is round-robin with burst locking, so a message from
// one source is never interleaved with bytes from another. A grant is held
// until the last byte of the message, MAX_BURST bytes, or the grantee drops
// valid, whichever comes first.
//
// Optional build macro: UART_ARB_ID_PREFIX_EN
//   When defined, every new grant first sends a header byte {4'hA,1'b0,g}
//   through the normal issue sequence. The header is never acked to the
//   requester, does not count toward MAX_BURST and never triggers a release.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant held; pick the next requester from the rr pointer
// ISSUE | grant held; wait for uart_tx ready and a pending grantee byte
// GUARD | one cycle after a handoff while uart_tx latches the byte
// DRAIN | wait for uart_tx to go ready again, then release or continue
//
// All outputs are registered, so tx_data_ready_o never has a combinational
// path from tx_ready_rcv_i (uart_tx ready depends on data_ready).

module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_ack_o,
    input  logic                 tx_ready_rcv_i,
    output logic                 tx_data_ready_o,
    output logic [7:0]           tx_data_o,
    output logic                 busy_o,
    output logic [2:0]           grant_id_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GUARD = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    state_t            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        gnt_q, gnt_d;
    logic [7:0]        burst_q, burst_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              txv_q, txv_d;
    logic [7:0]        txd_q, txd_d;
    logic [N_REQ-1:0]  ack_q, ack_d;

    logic              g_valid;
    logic              g_last;
    logic [7:0]        g_data;
    logic [2:0]        pick;
    logic [N_REQ-1:0]  hi_req;
    logic [2:0]        ptr_next;

    logic              hdr_pend;
    logic              is_hdr;

    logic              grant_now;
    logic              issue_now;
    logic              drain_done;
    logic              release_now;

    // Select the current grantee's valid, last flag and byte.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = 8'h00;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_q == 3'(k)) begin
                g_valid = req_valid_i[k];
                g_last  = req_last_i[k];
                g_data  = req_data_i[8*k +: 8];
            end
        end
    end

    // Round-robin pick: lowest requester at or above the pointer, else lowest overall.
    always_comb begin
        hi_req = '0;
        pick   = 3'd0;
        for (int k = 0; k < N_REQ; k++) begin
            hi_req[k] = req_valid_i[k] && (3'(k) >= ptr_q);
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k]) pick = 3'(k);
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (hi_req[k]) pick = 3'(k);
        end
    end

    assign ptr_next    = (gnt_q == 3'(N_REQ - 1)) ? 3'd0 : gnt_q + 3'd1;
    assign grant_now   = (state_q == IDLE) && (|req_valid_i);
    assign issue_now   = (state_q == ISSUE) && tx_ready_rcv_i && (hdr_pend || g_valid);
    assign drain_done  = (state_q == DRAIN) && tx_ready_rcv_i;
    assign release_now = drain_done && !is_hdr &&
                         (last_q || (burst_q == MAX_B) || !g_valid);

`ifdef UART_ARB_ID_PREFIX_EN
    logic hdr_pend_q, hdr_pend_d;
    logic is_hdr_q, is_hdr_d;

    assign hdr_pend = hdr_pend_q;
    assign is_hdr   = is_hdr_q;

    // Header bookkeeping: armed on each grant, consumed by the first issue.
    always_comb begin
        hdr_pend_d = hdr_pend_q;
        is_hdr_d   = is_hdr_q;
        if (grant_now) hdr_pend_d = 1'b1;
        if (issue_now) begin
            hdr_pend_d = 1'b0;
            is_hdr_d   = hdr_pend_q;
        end
    end

    // Header flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hdr_pend_q <= 1'b0;
            is_hdr_q   <= 1'b0;
        end else begin
            hdr_pend_q <= hdr_pend_d;
            is_hdr_q   <= is_hdr_d;
        end
    end
`else
    assign hdr_pend = 1'b0;
    assign is_hdr   = 1'b0;
`endif

    // State and registered-output flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            gnt_q   <= 3'd0;
            burst_q <= 8'd0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            txv_q   <= 1'b0;
            txd_q   <= 8'h00;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            burst_q <= burst_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            txv_q   <= txv_d;
            txd_q   <= txd_d;
            ack_q   <= ack_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_now) state_d = ISSUE;
            ISSUE:   if (issue_now) state_d = GUARD;
            GUARD:   state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = release_now ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; pulses default low every cycle.
    always_comb begin
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        burst_d = burst_q;
        last_d  = last_q;
        busy_d  = busy_q;
        txv_d   = 1'b0;
        txd_d   = txd_q;
        ack_d   = '0;

        if (grant_now) begin
            busy_d  = 1'b1;
            gnt_d   = pick;
            burst_d = 8'd0;
            last_d  = 1'b0;
        end

        if (issue_now) begin
            txv_d = 1'b1;
            if (hdr_pend) begin
                txd_d = {4'hA, 1'b0, gnt_q};
            end else begin
                txd_d   = g_data;
                burst_d = burst_q + 8'd1;
                last_d  = g_last;
                for (int k = 0; k < N_REQ; k++) begin
                    ack_d[k] = (gnt_q == 3'(k));
                end
            end
        end

        if (release_now) begin
            busy_d = 1'b0;
            ptr_d  = ptr_next;
        end
    end

    assign req_ack_o       = ack_q;
    assign tx_data_ready_o = txv_q;
    assign tx_data_o       = txd_q;
    assign busy_o          = busy_q;
    assign grant_id_o      = gnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle-stepped requesters and a uart_tx stub,
// with a transaction-level model of grants, bursts and the byte stream.
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 16;
    localparam int MEMD = 64;
`ifdef UART_ARB_ID_PREFIX_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_valid_i;
    logic [8*N-1:0]  req_data_i;
    logic [N-1:0]    req_last_i;
    logic [N-1:0]    req_ack_o;
    logic            tx_ready_rcv_i;
    logic            tx_data_ready_o;
    logic [7:0]      tx_data_o;
    logic            busy_o;
    logic [2:0]      grant_id_o;

    always #5 clk_i = ~clk_i;

    uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MAXB)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_data_i     (req_data_i),
        .req_last_i     (req_last_i),
        .req_ack_o      (req_ack_o),
        .tx_ready_rcv_i (tx_ready_rcv_i),
        .tx_data_ready_o(tx_data_ready_o),
        .tx_data_o      (tx_data_o),
        .busy_o         (busy_o),
        .grant_id_o     (grant_id_o)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Per-requester byte streams: bit 8 is the last-of-message flag.
    logic [8:0] mem [N][MEMD];
    int len [N];
    int head [N];
    int gap [N];

    int frame_cnt;
    bit hold;
    bit stall_en;

    // Reference model state.
    bit         m_busy, m_last, m_hdr;
    int         m_g, m_ptr, m_cnt;
    logic [7:0] m_txd;

    function automatic int ref_pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            req_valid_i[k] = (gap[k] == 0) && (head[k] < len[k]);
            if (head[k] < len[k]) begin
                req_data_i[8*k +: 8] = mem[k][head[k]][7:0];
                req_last_i[k]        = mem[k][head[k]][8];
            end
        end
        tx_ready_rcv_i = (frame_cnt == 0) && !hold &&
                         !(stall_en && ($urandom_range(0, 3) == 0));
    endtask

    task automatic step();
        logic [N-1:0] exp_ack;
        @(negedge clk_i);
        exp_ack = '0;
        if (rst_i) begin
            check_eq("rst_ack",  32'(req_ack_o), 32'd0);
            check_eq("rst_txv",  32'(tx_data_ready_o), 32'd0);
            check_eq("rst_txd",  32'(tx_data_o), 32'd0);
            check_eq("rst_busy", 32'(busy_o), 32'd0);
            check_eq("rst_gid",  32'(grant_id_o), 32'd0);
            m_busy = 1'b0; m_ptr = 0; m_cnt = 0; m_last = 1'b0; m_hdr = 1'b0; m_txd = 8'h00;
        end else begin
            if (!m_busy && busy_o) begin
                m_g = ref_pick(req_valid_i, m_ptr);
                check_eq("grant_id", 32'(grant_id_o), 32'(m_g));
                if (m_g < 0) m_g = 0;
                m_busy = 1'b1; m_cnt = 0; m_last = 1'b0; m_hdr = HDR;
            end
            if (tx_data_ready_o) begin
                check_eq("issue_rdy",  32'(tx_ready_rcv_i), 32'd1);
                check_eq("issue_busy", 32'(m_busy), 32'd1);
                if (m_hdr) begin
                    m_txd = {4'hA, 1'b0, 3'(m_g)};
                    m_hdr = 1'b0;
                end else begin
                    check_eq("burst_lock", 32'(m_last || (m_cnt == MAXB)), 32'd0);
                    if (head[m_g] < len[m_g]) begin
                        m_txd  = mem[m_g][head[m_g]][7:0];
                        m_last = mem[m_g][head[m_g]][8];
                    end
                    exp_ack[m_g] = 1'b1;
                    m_cnt++;
                end
            end
            check_eq("tx_data", 32'(tx_data_o), 32'(m_txd));
            check_eq("ack",     32'(req_ack_o), 32'(exp_ack));
            if (m_busy && !busy_o) begin
                check_eq("release_cond",
                         32'(m_last || (m_cnt == MAXB) || !req_valid_i[m_g]), 32'd1);
                m_busy = 1'b0;
                m_ptr  = (m_g + 1) % N;
            end
        end
        if (tx_data_ready_o) frame_cnt = $urandom_range(2, 8);
        else if (frame_cnt > 0) frame_cnt--;
        for (int k = 0; k < N; k++) begin
            if (req_ack_o[k] && head[k] < len[k]) begin
                if (mem[k][head[k]][8]) gap[k] = $urandom_range(0, 3);
                head[k]++;
            end else if (gap[k] > 0) begin
                gap[k]--;
            end
        end
        drive_inputs();
    endtask

    task automatic clear_msgs();
        for (int k = 0; k < N; k++) begin
            len[k] = 0; head[k] = 0; gap[k] = 0;
        end
    endtask

    task automatic add_msg(input int k, input int nbytes, input bit rnd, input logic [7:0] b);
        for (int i = 0; i < nbytes; i++) begin
            if (len[k] < MEMD) begin
                mem[k][len[k]][7:0] = rnd ? 8'($urandom_range(0, 255)) : b;
                mem[k][len[k]][8]   = (i == nbytes - 1);
                len[k]++;
            end
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    task automatic run_done(input string tag, input int budget);
        int  c;
        bit  done;
        c = 0;
        done = 1'b0;
        while (!done && c < budget) begin
            step();
            c++;
            done = !busy_o && !m_busy;
            for (int k = 0; k < N; k++) if (head[k] < len[k]) done = 1'b0;
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        int c;
        clear_msgs();
        hold = 1'b0; stall_en = 1'b0; frame_cnt = 0;
        m_busy = 1'b0; m_last = 1'b0; m_hdr = 1'b0; m_g = 0; m_ptr = 0; m_cnt = 0; m_txd = 8'h00;
        req_valid_i = '0; req_data_i = '0; req_last_i = '0;
        rst_i = 1'b1;
        drive_inputs();
        do_reset();

        // Single byte from requester 1, then pointer must sit at 2 (3 beats 0).
        add_msg(1, 1, 1'b0, 8'h55);
        drive_inputs();
        run_done("single", 200);
        add_msg(0, 1, 1'b1, 8'h00);
        add_msg(3, 1, 1'b1, 8'h00);
        drive_inputs();
        run_done("ptr2", 300);

        // Requester 0 three-byte message against requester 2.
        do_reset();
        clear_msgs();
        add_msg(0, 3, 1'b1, 8'h00);
        add_msg(2, 1, 1'b1, 8'h00);
        drive_inputs();
        run_done("burst3", 400);

        // 20-byte message from 3 is split at MAX_BURST, 0 served in between.
        do_reset();
        clear_msgs();
        add_msg(3, 20, 1'b1, 8'h00);
        add_msg(0, 2, 1'b1, 8'h00);
        gap[0] = 3;
        drive_inputs();
        run_done("maxburst", 2000);

        // uart_tx busy for 100 cycles: nothing issues; first pulse one cycle after ready.
        do_reset();
        clear_msgs();
        add_msg(0, 1, 1'b1, 8'h00);
        hold = 1'b1;
        drive_inputs();
        for (int i = 0; i < 100; i++) begin
            step();
            check_eq("hold_no_issue", 32'(tx_data_ready_o), 32'd0);
        end
        hold = 1'b0;
        drive_inputs();
        step();
        check_eq("first_pulse", 32'(tx_data_ready_o), 32'd1);
        run_done("hold", 200);

        // Reset while in GUARD mid-burst; remaining bytes follow after a new grant.
        do_reset();
        clear_msgs();
        add_msg(1, 4, 1'b1, 8'h00);
        drive_inputs();
        c = 0;
        do begin
            step();
            c++;
        end while (!tx_data_ready_o && c < 50);
        check_eq("guard_reached", 32'(tx_data_ready_o), 32'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        run_done("reissue", 500);

        // Requester 2 sends 0x41 (header-first in the prefix build).
        do_reset();
        clear_msgs();
        add_msg(2, 1, 1'b0, 8'h41);
        drive_inputs();
        run_done("byte41", 200);

        // Randomized traffic with uart stalls.
        do_reset();
        clear_msgs();
        stall_en = 1'b1;
        for (int k = 0; k < N; k++) begin
            int nm;
            nm = $urandom_range(1, 4);
            for (int m = 0; m < nm; m++) add_msg(k, $urandom_range(1, 20), 1'b1, 8'h00);
            gap[k] = $urandom_range(0, 5);
        end
        drive_inputs();
        run_done("random", 20000);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
